// File: rtl/i2c_master_core.sv
// ---------------------------------------------------------------------------
// i2c_master_core
// Single-byte I2C master: START, address+R/W, one data byte, STOP.
// One transaction per request; after completion the engine waits for the
// request to drop before it can launch again.
//
// Ports
//   PCLK, PRESETn          clock, synchronous active-low reset
//   i2c_addr/wdata/write   transaction descriptor, latched at launch
//   apb_data_valid         request, held until i2c_ready
//   i2c_ready              one-cycle completion pulse
//   i2c_error              NACK seen (address or write data), with i2c_ready
//   i2c_rdata              last successfully read byte
//   i2c_data_valid         read data valid, pulses with i2c_ready
//   sda_in                 synchronised SDA line
//   sda_oe / scl_oe        open-drain pull-down enables
//   busy                   transaction in flight (through STOP)
// ---------------------------------------------------------------------------
module i2c_master_core #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [6:0] i2c_addr,
  input  logic [7:0] i2c_wdata,
  input  logic       i2c_write,
  input  logic       apb_data_valid,
  output logic       i2c_ready,
  output logic       i2c_error,
  output logic [7:0] i2c_rdata,
  output logic       i2c_data_valid,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       busy
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_STOP,
    ST_DONE,
    ST_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      qidx_q, qidx_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rshift_q, rshift_d;
  logic            rd_q, rd_d;
  logic            err_q, err_d;

  logic            scl_oe_q, scl_oe_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;
  logic            dv_q, dv_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            q_end_c;
  logic            slot_end_c;
  logic            byte_end_c;
  logic            sample_c;
  logic            launch_c;

  // Quarter / slot boundary strobes
  assign q_end_c    = (qcnt_q == CW'(CLK_DIV - 1));
  assign slot_end_c = q_end_c && (qidx_q == 2'd3);
  assign byte_end_c = slot_end_c && (bitcnt_q == 3'd7);
  assign sample_c   = q_end_c && (qidx_q == 2'd2);
  assign launch_c   = (state_q == ST_IDLE) && apb_data_valid;

  // State register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (apb_data_valid) state_d = ST_START;
      ST_START: if (q_end_c && (qidx_q == 2'd1)) state_d = ST_ADDR;
      ST_ADDR:  if (byte_end_c) state_d = ST_AACK;
      // err_q already holds the ACK sampled at the end of q2
      ST_AACK:  if (slot_end_c) state_d = err_q ? ST_STOP : (rd_q ? ST_RDATA : ST_WDATA);
      ST_WDATA: if (byte_end_c) state_d = ST_WACK;
      ST_WACK:  if (slot_end_c) state_d = ST_STOP;
      ST_RDATA: if (byte_end_c) state_d = ST_RACK;
      ST_RACK:  if (slot_end_c) state_d = ST_STOP;
      ST_STOP:  if (q_end_c && (qidx_q == 2'd3)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_HOLD;
      ST_HOLD:  if (!apb_data_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: quarter timing, shift registers, error flag
  always_comb begin
    qcnt_d   = qcnt_q;
    qidx_d   = qidx_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    wdata_d  = wdata_q;
    rshift_d = rshift_q;
    rd_d     = rd_q;
    err_d    = err_q;

    if (state_q inside {ST_IDLE, ST_DONE, ST_HOLD}) begin
      qcnt_d = '0;
      qidx_d = '0;
    end else begin
      qcnt_d = q_end_c ? '0 : (qcnt_q + CW'(1));
      // Each state starts at q0; bit states wrap naturally 3 -> 0
      if (state_d != state_q) begin
        qidx_d = '0;
      end else if (q_end_c) begin
        qidx_d = qidx_q + 2'd1;
      end
    end

    if (launch_c) begin
      shift_d  = {i2c_addr, ~i2c_write};
      wdata_d  = i2c_wdata;
      rd_d     = ~i2c_write;
      err_d    = 1'b0;
      bitcnt_d = '0;
    end

    if ((state_q inside {ST_ADDR, ST_WDATA, ST_RDATA}) && slot_end_c) begin
      bitcnt_d = bitcnt_q + 3'd1;
    end

    case (state_q)
      ST_ADDR:  if (slot_end_c) shift_d = {shift_q[6:0], 1'b0};
      ST_WDATA: if (slot_end_c) wdata_d = {wdata_q[6:0], 1'b0};
      ST_RDATA: if (sample_c) rshift_d = {rshift_q[6:0], sda_in};
      ST_AACK,
      ST_WACK:  if (sample_c && sda_in) err_d = 1'b1;
      ST_DONE:  err_d = 1'b0;
      default:  ;
    endcase
  end

  // Output decode, registered one cycle behind the state
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    busy_d   = !(state_q inside {ST_IDLE, ST_DONE, ST_HOLD});
    ready_d  = 1'b0;
    error_d  = 1'b0;
    dv_d     = 1'b0;
    rdata_d  = rdata_q;

    case (state_q)
      ST_START: begin
        sda_oe_d = 1'b1;
        scl_oe_d = qidx_q[0];
      end
      ST_ADDR: begin
        scl_oe_d = ~qidx_q[1];
        sda_oe_d = ~shift_q[7];
      end
      ST_WDATA: begin
        scl_oe_d = ~qidx_q[1];
        sda_oe_d = ~wdata_q[7];
      end
      ST_AACK, ST_WACK, ST_RDATA, ST_RACK: begin
        // SDA released: slave ACK/data, or master NACK in RACK
        scl_oe_d = ~qidx_q[1];
      end
      ST_STOP: begin
        scl_oe_d = (qidx_q == 2'd0);
        sda_oe_d = ~qidx_q[1];
      end
      ST_DONE: begin
        ready_d = 1'b1;
        error_d = err_q;
        dv_d    = rd_q & ~err_q;
        if (rd_q && !err_q) rdata_d = rshift_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      qcnt_q   <= '0;
      qidx_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      wdata_q  <= '0;
      rshift_q <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      dv_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      qcnt_q   <= qcnt_d;
      qidx_q   <= qidx_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      wdata_q  <= wdata_d;
      rshift_q <= rshift_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      dv_q     <= dv_d;
      rdata_q  <= rdata_d;
    end
  end

  assign scl_oe         = scl_oe_q;
  assign sda_oe         = sda_oe_q;
  assign busy           = busy_q;
  assign i2c_ready      = ready_q;
  assign i2c_error      = error_q;
  assign i2c_data_valid = dv_q;
  assign i2c_rdata      = rdata_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_core
// Two masters (CLK_DIV=4 and CLK_DIV=2) checked against a quarter-level
// protocol model: each transaction is expanded into a list of bus quarters
// (SCL/SDA enables plus the slave's SDA response), then every cycle of the
// DUT is compared with the quarter it should be in.
// ---------------------------------------------------------------------------
module tb_i2c_master_core;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       valid  [2];
  logic       sin    [2];
  logic       rdy    [2];
  logic       err    [2];
  logic       dv     [2];
  logic       sda_oe [2];
  logic       scl_oe [2];
  logic       busy   [2];
  logic [7:0] rdata  [2];

  always #5 clk = ~clk;

  i2c_master_core #(.CLK_DIV(4)) u_div4 (
    .PCLK(clk), .PRESETn(rstn),
    .i2c_addr(addr), .i2c_wdata(wdata), .i2c_write(wr),
    .apb_data_valid(valid[0]),
    .i2c_ready(rdy[0]), .i2c_error(err[0]), .i2c_rdata(rdata[0]),
    .i2c_data_valid(dv[0]),
    .sda_in(sin[0]), .sda_oe(sda_oe[0]), .scl_oe(scl_oe[0]), .busy(busy[0])
  );

  i2c_master_core #(.CLK_DIV(2)) u_div2 (
    .PCLK(clk), .PRESETn(rstn),
    .i2c_addr(addr), .i2c_wdata(wdata), .i2c_write(wr),
    .apb_data_valid(valid[1]),
    .i2c_ready(rdy[1]), .i2c_error(err[1]), .i2c_rdata(rdata[1]),
    .i2c_data_valid(dv[1]),
    .sda_in(sin[1]), .sda_oe(sda_oe[1]), .scl_oe(scl_oe[1]), .busy(busy[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: one entry per bus quarter
  bit m_scl[$];
  bit m_sda[$];
  bit m_sin[$];
  bit exp_err;
  bit exp_dv;
  logic [7:0] cur_rdata [2];

  // Observed bus bits (master's SDA at each SCL rising edge)
  bit bus_bits[$];
  int r_at;
  int r_pulses;
  logic r_err;
  logic r_dv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void push_q(bit scl, bit sda, bit s);
    m_scl.push_back(scl);
    m_sda.push_back(sda);
    m_sin.push_back(s);
  endfunction

  // Bit slot: SCL low for two quarters, released for two; SDA = ~bit all slot
  function automatic void push_slot(bit b, bit s);
    push_q(1'b1, ~b, s);
    push_q(1'b1, ~b, s);
    push_q(1'b0, ~b, s);
    push_q(1'b0, ~b, s);
  endfunction

  function automatic void push_byte(logic [7:0] v, logic [7:0] sv);
    for (int i = 7; i >= 0; i--) push_slot(v[i], sv[i]);
  endfunction

  function automatic void build_model(bit is_wr, logic [6:0] a, logic [7:0] wd,
                                      bit aack, bit dack, logic [7:0] rb);
    m_scl.delete();
    m_sda.delete();
    m_sin.delete();
    push_q(1'b0, 1'b1, 1'b1);                 // START: SDA falls, SCL high
    push_q(1'b1, 1'b1, 1'b1);
    push_byte({a, ~is_wr}, 8'hFF);
    push_slot(1'b1, ~aack);                   // slave pulls low to ACK
    if (aack) begin
      if (is_wr) begin
        push_byte(wd, 8'hFF);
        push_slot(1'b1, ~dack);
      end else begin
        push_byte(8'hFF, rb);
        push_slot(1'b1, 1'b1);                // master NACK
      end
    end
    push_q(1'b1, 1'b1, 1'b1);                 // STOP
    push_q(1'b0, 1'b1, 1'b1);
    push_q(1'b0, 1'b0, 1'b1);
    push_q(1'b0, 1'b0, 1'b1);
    exp_err = !aack || (is_wr && !dack);
    exp_dv  = !is_wr && aack;
  endfunction

  function automatic logic [7:0] bus_byte(int start);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (start + i < bus_bits.size()) v[7-i] = bus_bits[start+i];
    return v;
  endfunction

  // Launch one transaction on instance inst and compare every cycle
  task automatic run_txn(input int inst, input int d, input bit is_wr,
                         input logic [6:0] a, input logic [7:0] wd,
                         input bit aack, input bit dack, input logic [7:0] rb,
                         input int abort_at);
    int nq, last;
    bit stop_loop;
    logic p_scl, p_sda, p_busy;
    logic e_scl, e_sda, e_busy, e_rdy, e_err, e_dv;
    logic [7:0] e_rd;
    logic [13:0] e_v, a_v;

    build_model(is_wr, a, wd, aack, dack, rb);
    nq    = m_scl.size();
    last  = nq * d + 1;
    addr  = a;
    wdata = wd;
    wr    = is_wr;
    sin[inst]   = 1'b1;
    valid[inst] = 1'b1;
    @(posedge clk); #1;                       // launch edge
    r_at = -1; r_pulses = 0; r_err = 1'b0; r_dv = 1'b0;
    bus_bits.delete();
    p_scl = scl_oe[inst]; p_sda = sda_oe[inst]; p_busy = busy[inst];
    stop_loop = 1'b0;

    for (int k = 0; k <= last + 2 && !stop_loop; k++) begin
      if (k >= 1 && k <= nq * d) begin
        e_scl  = m_scl[(k-1)/d];
        e_sda  = m_sda[(k-1)/d];
        e_busy = 1'b1;
      end else begin
        e_scl = 1'b0; e_sda = 1'b0; e_busy = 1'b0;
      end
      e_rdy = (k == last);
      e_err = e_rdy && exp_err;
      e_dv  = e_rdy && exp_dv;
      e_rd  = (k >= last && exp_dv) ? rb : cur_rdata[inst];
      e_v   = {e_busy, e_scl, e_sda, e_rdy, e_err, e_dv, e_rd};
      a_v   = {busy[inst], scl_oe[inst], sda_oe[inst], rdy[inst], err[inst], dv[inst], rdata[inst]};
      check($sformatf("cycle inst%0d k%0d {busy,scl,sda,rdy,err,dv,rdata}", inst, k), 32'(a_v), 32'(e_v));

      if (rdy[inst]) begin
        r_pulses++;
        if (r_at < 0) begin
          r_at = k; r_err = err[inst]; r_dv = dv[inst];
        end
      end
      if (p_scl && !scl_oe[inst]) bus_bits.push_back(~sda_oe[inst]);
      // SDA may only move under a high SCL for START/STOP
      if (p_busy && busy[inst] && !p_scl && !scl_oe[inst] && k <= nq * d &&
          ((k - 1) / d) < nq - 4)
        check($sformatf("sda_stable inst%0d k%0d", inst, k), 32'(sda_oe[inst]), 32'(p_sda));
      p_scl = scl_oe[inst]; p_sda = sda_oe[inst]; p_busy = busy[inst];

      if (k == abort_at) begin
        rstn = 1'b0;
        valid[inst] = 1'b0;
        @(posedge clk); #1;
        check("reset_mid {scl,sda,busy,rdy}",
              32'({scl_oe[inst], sda_oe[inst], busy[inst], rdy[inst]}), 32'h0);
        check("reset_mid rdata", 32'(rdata[inst]), 32'h0);
        cur_rdata[0] = '0;
        cur_rdata[1] = '0;
        rstn = 1'b1;
        stop_loop = 1'b1;
      end else begin
        sin[inst] = (k >= 1 && k <= nq * d) ? m_sin[(k-1)/d] : 1'b1;
        @(posedge clk); #1;
      end
    end
    if (!stop_loop && exp_dv) cur_rdata[inst] = rb;
  endtask

  // Drop the request for one cycle so the engine re-arms
  task automatic drop(input int inst);
    valid[inst] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    addr = '0; wdata = '0; wr = 1'b0;
    valid[0] = 1'b0; valid[1] = 1'b0;
    sin[0] = 1'b1; sin[1] = 1'b1;
    cur_rdata[0] = '0; cur_rdata[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset inst%0d", i),
            32'({busy[i], scl_oe[i], sda_oe[i], rdy[i], err[i], dv[i], rdata[i]}), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Write, ACK everywhere
    run_txn(0, 4, 1'b1, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, -1);
    check("write ready latency", 32'(r_at), 32'd313);
    check("write ready pulses", 32'(r_pulses), 32'd1);
    check("write error", 32'(r_err), 32'd0);
    check("write addr byte", 32'(bus_byte(0)), 32'hA0);
    check("write data byte", 32'(bus_byte(9)), 32'hA5);
    drop(0);

    // Read
    run_txn(0, 4, 1'b0, 7'h3C, 8'h00, 1'b1, 1'b1, 8'h5A, -1);
    check("read addr byte", 32'(bus_byte(0)), 32'h79);
    check("read rack nack", 32'(bus_bits[17]), 32'd1);
    check("read ready latency", 32'(r_at), 32'd313);
    check("read data_valid", 32'(r_dv), 32'd1);
    drop(0);
    check("read rdata held", 32'(rdata[0]), 32'h5A);

    // Address NACK
    run_txn(0, 4, 1'b0, 7'h22, 8'h00, 1'b0, 1'b1, 8'hC3, -1);
    check("anack ready latency", 32'(r_at), 32'd169);
    check("anack error", 32'(r_err), 32'd1);
    check("anack data_valid", 32'(r_dv), 32'd0);
    check("anack bus bit count", 32'(bus_bits.size()), 32'd10);
    drop(0);
    check("anack rdata unchanged", 32'(rdata[0]), 32'h5A);

    // Write data NACK
    run_txn(0, 4, 1'b1, 7'h11, 8'h3C, 1'b1, 1'b0, 8'h00, -1);
    check("dnack ready latency", 32'(r_at), 32'd313);
    check("dnack error", 32'(r_err), 32'd1);
    drop(0);

    // Reset during WDATA bit 3, then a clean request
    run_txn(0, 4, 1'b1, 7'h55, 8'hF0, 1'b1, 1'b1, 8'h00, 203);
    run_txn(0, 4, 1'b1, 7'h55, 8'hF0, 1'b1, 1'b1, 8'h00, -1);
    check("post-reset ready latency", 32'(r_at), 32'd313);
    check("post-reset error", 32'(r_err), 32'd0);
    drop(0);

    // Back-to-back on the CLK_DIV=2 engine
    run_txn(1, 2, 1'b1, 7'h0F, 8'h81, 1'b1, 1'b1, 8'h00, -1);
    check("b2b first latency", 32'(r_at), 32'd157);
    drop(1);
    run_txn(1, 2, 1'b0, 7'h70, 8'h00, 1'b1, 1'b1, 8'h96, -1);
    check("b2b second latency", 32'(r_at), 32'd157);
    check("b2b second rdata", 32'(rdata[1]), 32'h96);
    drop(1);

    // Randomized transactions on either engine
    for (int t = 0; t < 16; t++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      run_txn(inst, (inst == 0) ? 4 : 2, 1'($urandom_range(0, 1)),
              7'($urandom), 8'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              8'($urandom), -1);
      check($sformatf("rand t%0d pulses", t), 32'(r_pulses), 32'd1);
      drop(inst);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
- Single-byte I2C master engine directly downstream of the APB controller.
- Launches one I2C transaction on `apb_data_valid`, using the controller's `i2c_addr`, `i2c_wdata` and `i2c_write`.
- Transaction sequence: START, address+R/W, one data byte, STOP.
- Returns `i2c_ready`, `i2c_error`, `i2c_rdata` and `i2c_data_valid` to the controller.
- Drives open-drain SCL/SDA enables. No clock stretching, no multi-master arbitration.

Parameters:
- `CLK_DIV`, default 4: PCLK cycles per SCL quarter-period. Legal range ≥ 2. SCL period = 4*CLK_DIV PCLK cycles.

Ports:
- `PCLK` in 1: clock.
- `PRESETn` in 1: reset, synchronous, active-low.
- `i2c_addr` in 7: 7-bit target address.
- `i2c_wdata` in 8: write data byte.
- `i2c_write` in 1: 1 = write, 0 = read.
- `apb_data_valid` in 1: request; held high by the controller until `i2c_ready`.
- `i2c_ready` out 1: one-cycle completion pulse.
- `i2c_error` out 1: NACK indication, valid with `i2c_ready`.
- `i2c_rdata` out 8: read byte, held until the next read completes.
- `i2c_data_valid` out 1: read data valid, pulses with `i2c_ready` on a successful read.
- `sda_in` in 1: sampled SDA line (already synchronised).
- `sda_oe` out 1: 1 pulls SDA low, 0 releases it.
- `scl_oe` out 1: 1 pulls SCL low, 0 releases it.
- `busy` out 1: high from launch through STOP.

Behaviour:
- Clock and reset:
  - One clock, PCLK.
  - Reset is synchronous, active-low, on PRESETn.
  - Reset values: all outputs 0, `i2c_rdata` = 0, FSM in IDLE, quarter counter 0.
  - Reset mid-transfer: both lines released on the next edge. No STOP is generated.
- Launch:
  - Condition: FSM in IDLE and `apb_data_valid` = 1.
  - On that edge, latch `shift = {i2c_addr, ~i2c_write}`, `i2c_wdata` and the direction.
  - Inputs are ignored after latch.
- Re-arm:
  - After DONE the FSM sits in HOLD until `apb_data_valid` = 0, then returns to IDLE.
  - A held-high valid therefore never starts a second transaction.
- Timing unit:
  - Quarter counter runs 0..CLK_DIV-1; quarter index runs q0..q3.
  - Every state step below occurs on quarter boundaries only.
- States:
  - **IDLE**: both lines released.
  - **START** (2 quarters):
    - q0: SDA low, SCL released.
    - q1: SDA low, SCL low.
  - **ADDR**: 8 bits, MSB first.
  - **ADDR_ACK**: 1 bit, SDA released; sample ACK.
    - Sampled `sda_in` = 1 (NACK) sets an error flag and goes to STOP.
    - Otherwise goes to WDATA if write, RDATA if read.
  - **WDATA**: 8 bits from the latched `i2c_wdata`, MSB first.
  - **WACK**: SDA released; sample ACK. NACK sets the error flag. Then STOP.
  - **RDATA**: SDA released; shift `sda_in` MSB first.
  - **RACK**: master drives NACK (SDA released). Then STOP.
  - **STOP** (4 quarters):
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2–q3: both released.
  - **DONE**: 1 cycle.
    - `i2c_ready` = 1; `i2c_error` = error flag.
    - On a read with no error: `i2c_data_valid` = 1 and `i2c_rdata` updated.
    - Error flag clears.
  - **HOLD**: wait for `apb_data_valid` = 0 (see Re-arm).
- Bit slot (4 quarters):
  - q0: SCL low; SDA set to the bit (`sda_oe = ~bit`) at the start of q0.
  - q1: SCL low.
  - q2–q3: SCL released.
  - `sda_in` is sampled on the last PCLK of q2.
  - SDA never changes while SCL is released, except during START and STOP.
- Latency, measured from the launch edge to `i2c_ready`:
  - Full transaction: 78*CLK_DIV + 1 cycles.
  - Address NACK: 42*CLK_DIV + 1 cycles.
- `busy`: 1 from the cycle after launch through the last STOP quarter; 0 in DONE, HOLD and IDLE.
- Outputs in DONE:
  - `i2c_error` and `i2c_data_valid` are 0 whenever `i2c_ready` = 0.
  - `i2c_error` and `i2c_data_valid` are never both 1.
  - A read with a NACKed address leaves `i2c_rdata` unchanged.

Test Plan:
- Write, ACK everywhere:
  - Stimulus: CLK_DIV=4, addr=0x50, wdata=0xA5, write=1, valid held.
  - Required: SDA bits 1010_0000, then 1010_0101.
  - Required: `i2c_ready` pulse 313 cycles after launch with `i2c_error` = 0; exactly one pulse while valid stays high.
- Read:
  - Stimulus: addr=0x3C, read; slave ACKs the address and drives 0x5A.
  - Required: address byte 0111_1001; master NACK in RACK.
  - Required: `i2c_ready` = `i2c_data_valid` = 1 for one cycle with `i2c_rdata` = 0x5A; `i2c_rdata` still 0x5A afterwards.
- Address NACK:
  - Stimulus: `sda_in` held 1.
  - Required: no data phase; STOP follows ADDR_ACK.
  - Required: `i2c_ready` = `i2c_error` = 1 at 169 cycles; `i2c_data_valid` = 0.
- Write data NACK:
  - Stimulus: slave ACKs the address, NACKs the data.
  - Required: full-length transaction with `i2c_error` = 1 at 313 cycles.
- Reset mid-transfer:
  - Stimulus: PRESETn low during WDATA bit 3, then a new request.
  - Required: next edge gives `scl_oe` = `sda_oe` = `busy` = `i2c_ready` = 0 and FSM in IDLE.
  - Required: the new request completes normally.
- Back-to-back with CLK_DIV=2:
  - Stimulus: valid dropped for 1 cycle after `i2c_ready`, then reasserted.
  - Required: second START begins the cycle after relaunch.
  - Required: SDA is stable across every SCL-high window, checked by assertion.
